// File: rtl/lfsr_rand_gen_pkg.sv
// Shared game package: draw FSM states, default LFSR configurations and the
// range-to-mask helper used by the bounded random draw.
package lfsr_rand_gen_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } draw_state_e;

  // 8-bit defaults reproduce the legacy free-running game sequence.
  localparam logic [7:0]  TAPS_8  = 8'h1C;
  localparam logic [7:0]  SEED_8  = 8'h1C;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;

  // Widest draw the mask helper supports.
  localparam int MASK_MAX_W = 32;

  // Smallest (2^n - 1) covering range_val - 1: smear the top set bit of
  // range_val - 1 downwards. range_val = 0 wraps to all ones (full range),
  // range_val = 1 gives 0.
  function automatic logic [MASK_MAX_W-1:0] range_mask(input logic [MASK_MAX_W-1:0] range_val);
    logic [MASK_MAX_W-1:0] m;
    m = range_val - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// Fibonacci-style right-shifting LFSR with seed load and zero-lockup recovery.
module lfsr_rand_gen_core
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
  parameter logic [WIDTH-1:0] SEED  = SEED_16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_state;

  assign w_fb         = ^(r_state & TAPS);
  assign w_shift      = {w_fb, r_state[WIDTH-1:1]};
  // An all-zero state would lock the register forever; fall back to SEED.
  assign w_step_val   = (w_shift == '0) ? SEED : w_shift;
  assign w_load_state = (i_load_val == '0) ? SEED : i_load_val;

  // State register: reset to SEED, seed load beats stepping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= w_load_state;
    end else if (i_step) begin
      r_state <= w_step_val;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random generator with a request/valid draw port returning values
// bounded to [0, range) by masked rejection sampling.
module lfsr_rand_gen
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_16,
  parameter logic [WIDTH-1:0] SEED      = SEED_16,
  parameter int               OUT_W     = 8,   // <= WIDTH and <= MASK_MAX_W
  parameter int               MAX_TRIES = 15   // >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step_en,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_req,
  input  logic [OUT_W-1:0] i_range,
  output logic             o_busy,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_rand_out,
  output logic             o_fail,
  output logic [WIDTH-1:0] o_raw
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  draw_state_e      r_state,  w_state_nxt;
  logic [OUT_W-1:0] r_range,  w_range_nxt;
  logic [OUT_W-1:0] r_rand,   w_rand_nxt;
  logic [TRY_W-1:0] r_tries,  w_tries_nxt;
  logic             r_valid,  w_valid_nxt;
  logic             r_fail,   w_fail_nxt;

  logic [WIDTH-1:0] w_lfsr;
  logic             w_step;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_cand;
  logic             w_hit;
  logic [TRY_W-1:0] w_tries_inc;

  // The search consumes one LFSR step per cycle on top of the free-run tick.
  assign w_step = i_step_en || (r_state == ST_SEARCH);

  lfsr_rand_gen_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_step),
    .i_load     (i_seed_load),
    .i_load_val (i_seed_in),
    .o_state    (w_lfsr)
  );

  // Candidate comes from the current (pre-step) state, masked to the
  // smallest power-of-two window covering the latched range.
  assign w_mask      = OUT_W'(range_mask(MASK_MAX_W'(r_range)));
  assign w_cand      = w_lfsr[OUT_W-1:0] & w_mask;
  assign w_hit       = (r_range == '0) || (w_cand < r_range);
  assign w_tries_inc = r_tries + 1'b1;

  // Draw FSM next-state and result logic.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    w_state_nxt = r_state;
    w_range_nxt = r_range;
    w_tries_nxt = r_tries;
    w_rand_nxt  = r_rand;
    w_fail_nxt  = r_fail;
    w_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_state_nxt = ST_SEARCH;
          w_range_nxt = i_range;
          w_tries_nxt = '0;
        end
      end
      ST_SEARCH: begin
        // A seed load replaces this cycle's evaluation; search resumes next cycle.
        if (!i_seed_load) begin
          if (w_hit) begin
            w_rand_nxt  = w_cand;
            w_fail_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tries_nxt = w_tries_inc;
            if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
              w_rand_nxt  = '0;
              w_fail_nxt  = 1'b1;
              w_valid_nxt = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Draw FSM and result registers; reset aborts any draw in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_range <= '0;
      r_tries <= '0;
      r_rand  <= '0;
      r_fail  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_range <= w_range_nxt;
      r_tries <= w_tries_nxt;
      r_rand  <= w_rand_nxt;
      r_fail  <= w_fail_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_busy     = (r_state == ST_SEARCH);
  assign o_valid    = r_valid;
  assign o_rand_out = r_rand;
  assign o_fail     = r_fail;
  assign o_raw      = w_lfsr;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench: two 8-bit legacy-config instances (MAX_TRIES 15 and 1)
// share one randomized stimulus stream; each is compared every cycle against
// a behavioural model, with literal checks pinning the model's key values.
module tb_lfsr_rand_gen;

  localparam logic [7:0] TAPS_T = 8'h1C;
  localparam logic [7:0] SEED_T = 8'h1C;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       req;
  logic [7:0] range_in;

  logic       a_busy, a_valid, a_fail;
  logic [7:0] a_rand, a_raw;
  logic       b_busy, b_valid, b_fail;
  logic [7:0] b_rand, b_raw;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_rand_gen #(
    .WIDTH(8), .TAPS(TAPS_T), .SEED(SEED_T), .OUT_W(8), .MAX_TRIES(15)
  ) u_dut_a (
    .clk(clk), .rst(rst), .i_step_en(step_en), .i_seed_load(seed_load),
    .i_seed_in(seed_in), .i_req(req), .i_range(range_in),
    .o_busy(a_busy), .o_valid(a_valid), .o_rand_out(a_rand),
    .o_fail(a_fail), .o_raw(a_raw)
  );

  lfsr_rand_gen #(
    .WIDTH(8), .TAPS(TAPS_T), .SEED(SEED_T), .OUT_W(8), .MAX_TRIES(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .i_step_en(step_en), .i_seed_load(seed_load),
    .i_seed_in(seed_in), .i_req(req), .i_range(range_in),
    .o_busy(b_busy), .o_valid(b_valid), .o_rand_out(b_rand),
    .o_fail(b_fail), .o_raw(b_raw)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int lfsr;
    bit busy;
    int rng;
    int tries;
    bit valid;
    bit fail;
    int rout;
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic int mask_of(int r);
    int p;
    if (r == 0) return 255;
    p = 1;
    while (p < r) p = p * 2;
    return p - 1;
  endfunction

  function automatic int lfsr_step(int s);
    int fb;
    int n;
    fb = $countones(s & int'(TAPS_T)) % 2;
    n  = (fb << 7) | (s >> 1);
    return (n == 0) ? int'(SEED_T) : n;
  endfunction

  function automatic mdl_t model_tick(mdl_t m, int max_tries);
    mdl_t n;
    int   cand;
    int   load_v;
    n      = m;
    load_v = (seed_in == 8'd0) ? int'(SEED_T) : int'(seed_in);
    if (rst) begin
      n      = '{default: 0};
      n.lfsr = int'(SEED_T);
      return n;
    end
    n.valid = 1'b0;
    if (!m.busy) begin
      if (req) begin
        n.busy  = 1'b1;
        n.rng   = int'(range_in);
        n.tries = 0;
      end
      if (seed_load)    n.lfsr = load_v;
      else if (step_en) n.lfsr = lfsr_step(m.lfsr);
    end else if (seed_load) begin
      n.lfsr = load_v;
    end else begin
      cand   = m.lfsr & mask_of(m.rng);
      n.lfsr = lfsr_step(m.lfsr);
      if (m.rng == 0 || cand < m.rng) begin
        n.rout  = cand;
        n.valid = 1'b1;
        n.fail  = 1'b0;
        n.busy  = 1'b0;
      end else begin
        n.tries = m.tries + 1;
        if (n.tries == max_tries) begin
          n.rout  = 0;
          n.fail  = 1'b1;
          n.valid = 1'b1;
          n.busy  = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // Advance both models on each active edge from the inputs held since the last negedge.
  always @(posedge clk) begin
    ma = model_tick(ma, 15);
    mb = model_tick(mb, 1);
  end

  // Compare both DUTs against their models on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_raw",   32'(a_raw),   32'(ma.lfsr));
      check("a_busy",  32'(a_busy),  32'(ma.busy));
      check("a_valid", 32'(a_valid), 32'(ma.valid));
      check("a_fail",  32'(a_fail),  32'(ma.fail));
      check("a_rand",  32'(a_rand),  32'(ma.rout));
      check("b_raw",   32'(b_raw),   32'(mb.lfsr));
      check("b_busy",  32'(b_busy),  32'(mb.busy));
      check("b_valid", 32'(b_valid), 32'(mb.valid));
      check("b_fail",  32'(b_fail),  32'(mb.fail));
      check("b_rand",  32'(b_rand),  32'(mb.rout));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_valid;
    rst = 1'b1; step_en = 1'b0; seed_load = 1'b0; seed_in = 8'd0;
    req = 1'b0; range_in = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state and free-running steps.
    check("rst_raw",   32'(a_raw),   32'h1C);
    check("rst_valid", 32'(a_valid), 32'h0);
    check("rst_busy",  32'(a_busy),  32'h0);
    step_en = 1'b1;
    tick(); check("step1_raw", 32'(a_raw), 32'h8E);
    tick(); check("step2_raw", 32'(a_raw), 32'h47);
    step_en = 1'b0;

    // Full-range draw straight after reset: minimum latency.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 1'b1; range_in = 8'd0;
    tick(); req = 1'b0;
    check("full_busy",  32'(a_busy),  32'h1);
    check("full_valid0", 32'(a_valid), 32'h0);
    tick();
    check("full_valid", 32'(a_valid), 32'h1);
    check("full_rand",  32'(a_rand),  32'h1C);
    check("full_fail",  32'(a_fail),  32'h0);
    check("full_raw",   32'(a_raw),   32'h8E);
    check("full_busy0", 32'(a_busy),  32'h0);

    // Seed 0x7F, range 100: one rejection then 63 (A); immediate fail (B).
    seed_load = 1'b1; seed_in = 8'h7F;
    tick(); seed_load = 1'b0;
    check("seed_raw", 32'(a_raw), 32'h7F);
    req = 1'b1; range_in = 8'd100;
    tick(); req = 1'b0;
    check("r100_busy", 32'(a_busy), 32'h1);
    tick();
    check("r100_wait_valid", 32'(a_valid), 32'h0);
    check("r100_wait_busy",  32'(a_busy),  32'h1);
    check("b_fail_valid", 32'(b_valid), 32'h1);
    check("b_fail_fail",  32'(b_fail),  32'h1);
    check("b_fail_rand",  32'(b_rand),  32'h0);
    tick();
    check("r100_valid", 32'(a_valid), 32'h1);
    check("r100_rand",  32'(a_rand),  32'd63);
    check("r100_fail",  32'(a_fail),  32'h0);

    // range = 1 always yields 0 without failing, even with MAX_TRIES = 1.
    req = 1'b1; range_in = 8'd1;
    tick(); req = 1'b0;
    tick();
    check("r1_b_valid", 32'(b_valid), 32'h1);
    check("r1_b_fail",  32'(b_fail),  32'h0);
    check("r1_b_rand",  32'(b_rand),  32'h0);
    check("r1_a_rand",  32'(a_rand),  32'h0);

    // Zero seed maps to SEED; a step into all-zero reloads SEED.
    seed_load = 1'b1; seed_in = 8'h00;
    tick(); check("zero_seed_raw", 32'(a_raw), 32'h1C);
    seed_in = 8'h01;
    tick(); check("one_seed_raw", 32'(a_raw), 32'h01);
    seed_load = 1'b0; step_en = 1'b1;
    tick(); step_en = 1'b0;
    check("lockup_raw", 32'(a_raw), 32'h1C);

    // Reset mid-search: no valid, state back to SEED.
    seed_load = 1'b1; seed_in = 8'h7F;
    tick(); seed_load = 1'b0;
    req = 1'b1; range_in = 8'd100;
    tick(); req = 1'b0;
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("abort_valid", 32'(a_valid), 32'h0);
    check("abort_busy",  32'(a_busy),  32'h0);
    check("abort_raw",   32'(a_raw),   32'h1C);
    tick();
    check("abort_late_valid", 32'(a_valid), 32'h0);

    // req held while busy is ignored: exactly one valid.
    seed_load = 1'b1; seed_in = 8'h7F;
    tick(); seed_load = 1'b0;
    req = 1'b1; range_in = 8'd100;
    n_valid = 0;
    repeat (2) begin
      tick();
      if (a_valid) n_valid++;
    end
    req = 1'b0;
    repeat (8) begin
      tick();
      if (a_valid) n_valid++;
    end
    check("single_valid", 32'(n_valid), 32'd1);

    // Randomized traffic checked cycle by cycle against the models.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      step_en   = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 15) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      req       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       range_in = 8'd0;
        1:       range_in = 8'd1;
        2:       range_in = 8'(1 << $urandom_range(0, 7));
        3:       range_in = 8'($urandom_range(2, 255));
        default: range_in = 8'($urandom_range(129, 255));
      endcase
      tick();
    end
    rst = 1'b0; req = 1'b0; seed_load = 1'b0; step_en = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
